// File: rtl/fxp_add_arbiter.sv
// Round-robin arbiter sharing one fixed-point adder among NREQ requesters, with a single registered result slot.
// Optional: define FXP_ADD_ARBITER_SATURATE_EN to clamp overflowing results instead of wrapping.
module fxp_add_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIIA  = 8,
  parameter int WIFA  = 8,
  parameter int WIIB  = 8,
  parameter int WIFB  = 8,
  parameter int WOI   = 8,
  parameter int WOF   = 8,
  parameter int ROUND = 1,
  localparam int IDW  = (NREQ > 2) ? $clog2(NREQ) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NREQ-1:0]            req_valid,
  output logic [NREQ-1:0]            req_ready,
  input  logic [NREQ*(WIIA+WIFA)-1:0] req_ina,
  input  logic [NREQ*(WIIB+WIFB)-1:0] req_inb,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WOI+WOF-1:0]         out_data,
  output logic                       out_overflow,
  output logic [IDW-1:0]             out_id
);

  localparam int WA  = WIIA + WIFA;
  localparam int WB  = WIIB + WIFB;
  localparam int WO  = WOI + WOF;
  localparam int WII = (WIIA > WIIB) ? WIIA : WIIB;
  localparam int WIF = (WIFA > WIFB) ? WIFA : WIFB;
  localparam int WS  = WII + WIF + 1;
  // Internal integer width leaves headroom so rounding and truncation checks never lose the sign.
  localparam int IW  = (WII + 3 > WOI + 1) ? WII + 3 : WOI + 1;
  localparam int RW  = IW + WOF;

  logic [IDW-1:0] ptr;
  logic [IDW-1:0] gnt;
  logic           gnt_found;
  logic           can_load;
  logic           xfer;

  // NOTE: every combinational output gets a default at the top of the block so no latch is inferred.
  always_comb begin
    int j;
    gnt       = '0;
    gnt_found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      if (!gnt_found && req_valid[j]) begin
        gnt_found = 1'b1;
        gnt       = IDW'(j);
      end
    end
  end

  assign can_load = !out_valid || out_ready;
  assign xfer     = gnt_found && can_load && !rst;

  always_comb begin
    req_ready = '0;
    if (xfer) req_ready[gnt] = 1'b1;
  end

  logic signed [WA-1:0] a_s;
  logic signed [WB-1:0] b_s;
  logic signed [WS-1:0] a_al;
  logic signed [WS-1:0] b_al;
  logic signed [WS-1:0] sum_s;
  logic signed [RW-1:0] r;

  assign a_s   = req_ina[gnt*WA +: WA];
  assign b_s   = req_inb[gnt*WB +: WB];
  assign a_al  = WS'(a_s) <<< (WIF - WIFA);
  assign b_al  = WS'(b_s) <<< (WIF - WIFB);
  assign sum_s = a_al + b_al;

  generate
    if (WOF >= WIF) begin : g_pad
      assign r = RW'(sum_s) <<< (WOF - WIF);
    end else begin : g_red
      localparam int D = WIF - WOF;
      logic signed [WS:0] bias;
      logic signed [WS:0] biased;
      // Half-away-from-zero: negative values get half-1 so the arithmetic shift still rounds outward.
      always_comb begin
        bias = '0;
        if (ROUND != 0)
          bias = sum_s[WS-1] ? (WS+1)'((1 << (D-1)) - 1) : (WS+1)'(1 << (D-1));
      end
      assign biased = (WS+1)'(sum_s) + bias;
      assign r      = RW'(biased >>> D);
    end
  endgenerate

  logic [RW-WO:0] top_bits;
  logic           ovf;
  logic [WO-1:0]  res;

  assign top_bits = r[RW-1:WO-1];
  assign ovf      = !((&top_bits) || (~|top_bits));

`ifdef FXP_ADD_ARBITER_SATURATE_EN
  assign res = !ovf ? r[WO-1:0]
             : (sum_s[WS-1] ? {1'b1, {(WO-1){1'b0}}} : {1'b0, {(WO-1){1'b1}}});
`else
  assign res = r[WO-1:0];
`endif

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_overflow <= 1'b0;
      out_id       <= '0;
      ptr          <= '0;
    end else if (xfer) begin
      out_valid    <= 1'b1;
      out_data     <= res;
      out_overflow <= ovf;
      out_id       <= gnt;
      ptr          <= (gnt == IDW'(NREQ-1)) ? '0 : gnt + 1'b1;
    end else if (out_ready) begin
      out_valid    <= 1'b0;
    end
  end

endmodule

// File: doc/fxp_add_arbiter.md
Name: fxp_add_arbiter

Overview:
- Shares one fixed-point adder datapath among NREQ requesters.
- Round-robin arbitration selects one operand pair per cycle. The pair is added with format alignment, and the result is registered into a single output slot.
- Each result carries the winning requester index.
- Sits between multiple fixed-point producers (filters, accumulators) and a single downstream consumer.

Parameters:
- NREQ, 4, number of requesters (2..16)
- WIIA, 8, integer bits of operand A
- WIFA, 8, fraction bits of operand A
- WIIB, 8, integer bits of operand B
- WIFB, 8, fraction bits of operand B
- WOI, 8, integer bits of result
- WOF, 8, fraction bits of result
- ROUND, 1, 1 = round-to-nearest on fraction reduction, 0 = truncate
- IDW, $clog2(NREQ) (min 1), derived local width of the requester index

Ports:
- clk  input  1  clock, all logic on rising edge
- rst  input  1  synchronous active-high reset
- req_valid  input  NREQ  per-requester operand valid
- req_ready  output  NREQ  per-requester accept, one-hot or zero
- req_ina  input  NREQ*(WIIA+WIFA)  packed operand A, requester i at slice i
- req_inb  input  NREQ*(WIIB+WIFB)  packed operand B, requester i at slice i
- out_valid  output  1  result slot holds a result
- out_ready  input  1  consumer accepts the result
- out_data  output  WOI+WOF  signed fixed-point sum
- out_overflow  output  1  sum did not fit WOI integer bits
- out_id  output  IDW  index of the requester that produced out_data

Behaviour:
- Interface: one clock, clk; synchronous active-high reset, rst.
- Reset values:
  - out_valid=0, out_data=0, out_overflow=0, out_id=0.
  - Round-robin pointer=0.
  - req_ready=0 during the rst cycle.
- Slot state:
  - EMPTY (out_valid=0) or FULL (out_valid=1).
  - can_load = !out_valid | out_ready.
- Arbitration, combinational:
  - Search req_valid starting at the pointer and wrapping modulo NREQ; the first set bit is the grant g.
  - req_ready[g]=1 only when can_load and !rst. All other req_ready bits are 0.
  - No requester is granted when can_load=0.
- Transfer on req_valid[g] & req_ready[g]:
  - Next cycle: out_valid=1, out_data=sum, out_overflow=flag, out_id=g.
  - Pointer becomes (g+1) mod NREQ.
  - Latency is exactly 1 cycle from accept to out_valid.
- Drain:
  - out_valid & out_ready with no new transfer gives out_valid=0 next cycle.
  - Simultaneous drain and load gives a full-throughput back-to-back update, one result per cycle.
- Stall: while out_valid & !out_ready, out_data, out_overflow and out_id hold stable.
- Pointer: unchanged in cycles without a transfer.
- Fairness: a continuously asserting requester waits at most NREQ-1 transfers.
- Arithmetic:
  - Align both operands to WII=max(WIIA,WIIB), WIF=max(WIFA,WIFB) by sign-extension and zero-padding only. No rounding at this step.
  - Signed add at WII+1 integer bits, which is exact.
  - Reduce to WOI.WOF: fraction per ROUND, where round half away from zero must not itself overflow silently. Integer bits are truncated.
  - out_overflow=1 iff the discarded integer bits differ from the result sign.
- Requester contract: operands must stay stable while req_valid=1 and not yet accepted. The block does not check this.
- Reset mid-operation: any held result is discarded, and out_valid=0 on the cycle after rst.
- No requester valid: no state change except drain.

Optional Feature:
- Macro: FXP_ADD_ARBITER_SATURATE_EN
- Defined: on overflow, out_data clamps to the maximum positive value 0111..1 if the exact sum is positive, else the minimum 1000..0. Direction comes from the sign of the exact WII+1 sum. out_overflow is still asserted.
- Undefined: out_data holds the wrapped, truncated value. No extra logic.

Test Plan:
- Basic add, Q8.8, NREQ=4: requester 2 sends ina=0x0180 (1.5), inb=0x0240 (2.25), out_ready=1 -> next cycle out_valid=1, out_data=0x03C0, out_overflow=0, out_id=2.
- Overflow: ina=0x7F00, inb=0x0200 -> out_overflow=1. out_data=0x8100 without the macro; 0x7FFF with FXP_ADD_ARBITER_SATURATE_EN.
- Round-robin: all four req_valid held high, out_ready=1, from reset -> grants and out_id sequence 0,1,2,3,0,1 on consecutive cycles, one req_ready bit per cycle.
- Backpressure: out_ready=0 for 3 cycles after a result -> out_data/out_id stable and req_ready=0. Then out_ready=1 -> same-cycle reload of the next requester, no bubble.
- Format alignment: WIIA=4, WIFA=12, WIIB=8, WIFB=4, WOI=8, WOF=2, ROUND=1. ina=0x1800 (1.5), inb=0x0014 (1.25) -> 2.75 exactly representable, out_data=0x00B (2.75 in Q8.2).
- Reset mid-stall: out_valid=1, out_ready=0, assert rst one cycle -> out_valid=0, pointer=0. The next grant goes to the lowest valid index.
